// File: rtl/mem_pkg.sv
// Shared definitions for the store buffer: default widths, entry type, pointer sizing.
package mem_pkg;

    localparam int unsigned WL_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 4;

    typedef struct packed {
        logic [WL_DEF-1:0] addr;
        logic [WL_DEF-1:0] data;
    } sb_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue: storage, head/tail pointers and occupancy count.
// Every entry is exported so the owner can do the forwarding compare.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int unsigned WL    = WL_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [WL-1:0] push_addr_i,
    input  logic [WL-1:0] push_data_i,
    input  logic          pop_i,
    output logic [PW-1:0] head_o,
    output logic [PW-1:0] tail_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [WL-1:0] addr_o [DEPTH],
    output logic [WL-1:0] data_o [DEPTH]
);

    logic [WL-1:0] addr_q [DEPTH];
    logic [WL-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i)  head_d = head_q + PW'(1);
        if (push_i) tail_d = tail_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents are deliberately not reset; push is already gated by reset upstream.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer between EX/MEM and a single-port data memory: queues stores behind
// loads, drains them on idle cycles, and forwards the youngest matching store to loads.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned WL    = WL_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ST_VALID,
    input  logic [WL-1:0] ST_ADDR,
    input  logic [WL-1:0] ST_DATA,
    input  logic          LD_VALID,
    input  logic [WL-1:0] LD_ADDR,
    output logic [WL-1:0] LD_DATA,
    output logic          LD_FWD,
    output logic          STALL,
    output logic          EMPTY,
    output logic          DMWE,
    output logic [WL-1:0] DMA,
    output logic [WL-1:0] DMWD,
    input  logic [WL-1:0] DMRD
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic          push, pop, bypass, drain;
    logic          fifo_full, fifo_empty;
    logic [PW-1:0] head, tail, idx;
    logic [PW:0]   count;
    logic [WL-1:0] ent_addr [DEPTH];
    logic [WL-1:0] ent_data [DEPTH];
    logic          hit;
    logic [WL-1:0] hit_data;

    sb_fifo #(.WL(WL), .DEPTH(DEPTH)) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_N),
        .push_i     (push),
        .push_addr_i(ST_ADDR),
        .push_data_i(ST_DATA),
        .pop_i      (pop),
        .head_o     (head),
        .tail_o     (tail),
        .count_o    (count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .addr_o     (ent_addr),
        .data_o     (ent_data)
    );

    assign bypass = ST_VALID & ~LD_VALID & fifo_empty;
    assign drain  = ~LD_VALID & ~fifo_empty;
    assign STALL  = RST_N & ST_VALID & LD_VALID & fifo_full;
    assign push   = RST_N & ST_VALID & ~STALL & ~bypass;
    assign pop    = RST_N & drain;
    assign EMPTY  = ~RST_N | fifo_empty;

    // Walk from the youngest entry (tail-1) toward head; the first match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(1) - PW'(i);
            if (!hit && ((PW+1)'(i) < count) && (ent_addr[idx] == LD_ADDR)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

    always_comb begin
        DMWE    = 1'b0;
        DMA     = LD_ADDR;
        DMWD    = '0;
        LD_DATA = DMRD;
        LD_FWD  = 1'b0;
        if (LD_VALID) begin
            if (hit) begin
                LD_DATA = hit_data;
                LD_FWD  = 1'b1;
            end
        end else if (drain) begin
            DMWE = 1'b1;
            DMA  = ent_addr[head];
            DMWD = ent_data[head];
        end else if (ST_VALID) begin
            DMWE = 1'b1;
            DMA  = ST_ADDR;
            DMWD = ST_DATA;
        end
        if (!RST_N) begin
            DMWE   = 1'b0;
            LD_FWD = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a behavioural word memory on the DM port.
module tb_mem_store_buffer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ST_VALID;
    logic [31:0] ST_ADDR, ST_DATA;
    logic        LD_VALID;
    logic [31:0] LD_ADDR;
    logic [31:0] LD_DATA;
    logic        LD_FWD, STALL, EMPTY, DMWE;
    logic [31:0] DMA, DMWD, DMRD;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [64];
    logic [63:0] written = '0;
    int          wcount  = 0;

    always #5 CLK = ~CLK;

    mem_store_buffer #(.WL(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ST_VALID(ST_VALID), .ST_ADDR(ST_ADDR), .ST_DATA(ST_DATA),
        .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR),
        .LD_DATA(LD_DATA), .LD_FWD(LD_FWD), .STALL(STALL), .EMPTY(EMPTY),
        .DMWE(DMWE), .DMA(DMA), .DMWD(DMWD), .DMRD(DMRD)
    );

    function automatic logic [31:0] init_val(input logic [5:0] a);
        if (a == 6'd8)  return 32'h99;
        if (a == 6'd20) return 32'h2020;
        return 32'h0;
    endfunction

    function automatic logic [31:0] rd(input logic [5:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    assign DMRD = rd(DMA[5:0]);

    always @(posedge CLK) begin
        if (DMWE) begin
            mem[DMA[5:0]]     <= DMWD;
            written[DMA[5:0]] <= 1'b1;
            if (DMA >= 32'd40 && DMA <= 32'd45) wcount <= wcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] ref_m [6];
        int          mcount;
        int          idx;
        int          k;
        logic        ld, stall_exp;

        // reset with a would-be bypass store on the inputs
        RST_N = 1'b0; ST_VALID = 1'b1; ST_ADDR = 32'd5; ST_DATA = 32'hAA;
        LD_VALID = 1'b0; LD_ADDR = '0;
        #1;
        chk("rst_dmwe", {31'b0, DMWE}, 0);
        chk("rst_empty", {31'b0, EMPTY}, 1);
        chk("rst_stall", {31'b0, STALL}, 0);
        chk("rst_fwd", {31'b0, LD_FWD}, 0);
        tick(); tick();
        chk("rst_nowrite", rd(6'd5), 0);

        // bypass store
        RST_N = 1'b1;
        #1;
        chk("byp_dmwe", {31'b0, DMWE}, 1);
        chk("byp_dma", DMA, 5);
        chk("byp_dmwd", DMWD, 32'hAA);
        chk("byp_empty", {31'b0, EMPTY}, 1);
        tick();
        ST_VALID = 1'b0;
        #1;
        chk("byp_mem5", rd(6'd5), 32'hAA);
        chk("byp_empty_after", {31'b0, EMPTY}, 1);

        // fill behind loads, then stall
        LD_VALID = 1'b1; LD_ADDR = 32'd20; ST_VALID = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ST_ADDR = i; ST_DATA = i * 32'h10;
            #1;
            chk("fill_dmwe", {31'b0, DMWE}, 0);
            chk("fill_stall", {31'b0, STALL}, 0);
            chk("fill_dma", DMA, 20);
            if (i == 1) begin
                chk("fill_lddata", LD_DATA, 32'h2020);
                chk("fill_ldfwd", {31'b0, LD_FWD}, 0);
            end
            tick();
            chk("fill_empty", {31'b0, EMPTY}, 0);
        end
        ST_ADDR = 32'd5; ST_DATA = 32'h50;
        #1;
        chk("full_stall", {31'b0, STALL}, 1);
        chk("full_fwd_addr1", LD_DATA, 32'h2020);
        tick();
        LD_VALID = 1'b0;
        #1;
        chk("full_drain_stall", {31'b0, STALL}, 0);
        chk("full_drain_dmwe", {31'b0, DMWE}, 1);
        chk("full_drain_dma", DMA, 1);
        chk("full_drain_dmwd", DMWD, 32'h10);
        tick();
        ST_VALID = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            #1;
            chk("drain_dmwe", {31'b0, DMWE}, 1);
            chk("drain_dma", DMA, i);
            chk("drain_dmwd", DMWD, i * 32'h10);
            tick();
        end
        #1;
        chk("drain_empty", {31'b0, EMPTY}, 1);
        chk("drain_idle_dmwe", {31'b0, DMWE}, 0);
        chk("drain_mem1", rd(6'd1), 32'h10);
        chk("drain_mem5", rd(6'd5), 32'h50);
        tick();

        // forwarding: youngest match wins, same-cycle store not forwarded
        LD_VALID = 1'b1; LD_ADDR = 32'd8; ST_VALID = 1'b1; ST_ADDR = 32'd7; ST_DATA = 32'h11;
        #1;
        chk("fwd_miss_data", LD_DATA, 32'h99);
        chk("fwd_miss_flag", {31'b0, LD_FWD}, 0);
        tick();
        LD_ADDR = 32'd7; ST_DATA = 32'h22;
        #1;
        chk("fwd_old_data", LD_DATA, 32'h11);
        chk("fwd_old_flag", {31'b0, LD_FWD}, 1);
        tick();
        ST_VALID = 1'b0;
        #1;
        chk("fwd_young_data", LD_DATA, 32'h22);
        chk("fwd_young_flag", {31'b0, LD_FWD}, 1);
        LD_ADDR = 32'd8;
        #1;
        chk("fwd_mem_data", LD_DATA, 32'h99);
        chk("fwd_mem_flag", {31'b0, LD_FWD}, 0);
        tick();
        LD_VALID = 1'b0;
        #1;
        chk("fwd_drain1", DMWD, 32'h11);
        tick();
        #1;
        chk("fwd_drain2", DMWD, 32'h22);
        tick();
        chk("fwd_mem7", rd(6'd7), 32'h22);

        // reset mid-operation discards queued stores
        LD_VALID = 1'b1; LD_ADDR = 32'd20; ST_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ST_ADDR = 32'd30 + i; ST_DATA = 32'h300 + 32'h10 * i;
            tick();
        end
        ST_VALID = 1'b0;
        #1;
        chk("mrst_pre_empty", {31'b0, EMPTY}, 0);
        RST_N = 1'b0; LD_VALID = 1'b0;
        #1;
        chk("mrst_dmwe", {31'b0, DMWE}, 0);
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("mrst_empty", {31'b0, EMPTY}, 1);
            chk("mrst_idle_dmwe", {31'b0, DMWE}, 0);
            tick();
        end
        chk("mrst_mem30", rd(6'd30), 0);
        chk("mrst_mem32", rd(6'd32), 0);

        // wrap-around: alternating load/idle cycles against a program-order model
        for (int j = 0; j < 6; j++) ref_m[j] = 32'h0;
        mcount = 0; idx = 0; k = 0;
        while (idx < 10 && k < 40) begin
            ld = (k % 2 == 0);
            LD_VALID = ld; LD_ADDR = 32'd40 + 32'((k + 3) % 6);
            ST_VALID = 1'b1; ST_ADDR = 32'd40 + 32'(idx % 6); ST_DATA = 32'h500 + 32'(idx);
            #1;
            stall_exp = ld && (mcount == 4);
            chk("wrap_stall", {31'b0, STALL}, {31'b0, stall_exp});
            if (ld) chk("wrap_lddata", LD_DATA, ref_m[(k + 3) % 6]);
            if (!stall_exp) begin
                ref_m[idx % 6] = ST_DATA;
                if (ld) mcount++;
                idx++;
            end
            tick();
            k++;
        end
        chk("wrap_all_accepted", 32'(idx), 10);
        ST_VALID = 1'b0; LD_VALID = 1'b0;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (EMPTY) break;
            tick();
        end
        #1;
        chk("wrap_empty", {31'b0, EMPTY}, 1);
        chk("wrap_wcount", 32'(wcount), 10);
        for (int j = 0; j < 6; j++) chk("wrap_mem", rd(6'(40 + j)), ref_m[j]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Store buffer between the EX/MEM pipeline register and the single-port data memory.
- Queues stores while the memory port is busy serving loads, then drains them in program order on idle cycles.
- Loads see the newest value: the youngest matching buffered store is forwarded; otherwise the memory read data is passed through.
- Drives the data memory's write-enable, address and write-data inputs; consumes its combinational read data.

Parameters:
- WL, 32, data and address width in bits; the memory is word-indexed by the full address.
- DEPTH, 4, number of buffered stores; must be a power of 2 and at least 2.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous active-low reset
- ST_VALID  in  1  store request from EX/MEM
- ST_ADDR  in  WL  store word address
- ST_DATA  in  WL  store data
- LD_VALID  in  1  load request from EX/MEM
- LD_ADDR  in  WL  load word address
- LD_DATA  out  WL  load result to MEM/WB
- LD_FWD  out  1  load result came from the buffer
- STALL  out  1  store not accepted this cycle; upstream holds
- EMPTY  out  1  buffer holds no entries (used for halt/fence)
- DMWE  out  1  data memory write enable
- DMA  out  WL  data memory address
- DMWD  out  WL  data memory write data
- DMRD  in  WL  data memory read data (combinational)

Behaviour:
- State:
  - circular FIFO of DEPTH {addr,data} entries
  - head and tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH
  - count, 0..DEPTH
- Reset (RST_N=0 at posedge):
  - count=0, head=0, tail=0; entry contents are not reset.
  - While RST_N=0: DMWE=0, STALL=0, EMPTY=1, LD_FWD=0.
  - Reset mid-operation silently discards queued stores.
- Port arbitration (combinational, same cycle):
  - LD_VALID=1:
    - DMA=LD_ADDR, DMWE=0.
    - LD_DATA = data of the youngest entry whose addr equals LD_ADDR (full WL compare, searched from tail-1 back to head); else DMRD.
    - LD_FWD=1 only on a buffer hit.
  - LD_VALID=0, count>0 (drain):
    - DMA=head.addr, DMWD=head.data, DMWE=1.
    - Head pops at the posedge.
  - LD_VALID=0, count=0, ST_VALID=1 (bypass):
    - DMA=ST_ADDR, DMWD=ST_DATA, DMWE=1.
    - Nothing is enqueued.
  - Otherwise: DMWE=0, DMA=LD_ADDR, DMWD=0.
  - LD_DATA is don't-care when LD_VALID=0; drive DMRD.
- Enqueue:
  - Occurs when ST_VALID=1, STALL=0 and the cycle is not a bypass.
  - Writes {ST_ADDR,ST_DATA} at tail; tail advances.
- STALL = ST_VALID & LD_VALID & (count==DEPTH).
  - When full with no load, the drain frees a slot in the same cycle, so the store is accepted.
- Simultaneous push and pop: head and tail both advance; count unchanged.
- ST_VALID and LD_VALID both high:
  - The load is served and the store is enqueued (if not stalled).
  - The load does not forward from the same-cycle store.
- Ordering: drain order equals acceptance order, and a bypass only occurs when the buffer is empty, so memory sees program-order writes.
- EMPTY = (count==0).
- Latency:
  - load result: 0 cycles (combinational)
  - bypass store: written at the same posedge
  - buffered store: written at the first posedge with LD_VALID=0 and the entry at head
- count never exceeds DEPTH and never underflows; an enqueue into a full buffer without a pop is impossible by construction.

Decomposition:
- Shared package mem_pkg:
  - WL default constant
  - store-entry typedef {addr,data}
  - DEPTH default
  - pointer-width function (clog2)
- Sub-module sb_fifo: storage, pointers, count, push/pop, full/empty, with all entries exported for compare.
- The forwarding compare and port arbitration stay in mem_store_buffer.

Test Plan:
- Bypass store: reset, then ST_VALID=1, ST_ADDR=5, ST_DATA=0xAA, LD_VALID=0 -> same cycle DMWE=1, DMA=5, DMWD=0xAA; EMPTY stays 1; Mem[5]=0xAA after the edge.
- Fill and stall: LD_VALID=1 for 5 cycles (LD_ADDR=20) with stores to addr 1..5 (data 0x10..0x50).
  - Cycles 1-4: accepted, DMWE=0; EMPTY=0 after the first edge.
  - Cycle 5: STALL=1.
  - Drop LD_VALID: DMWE=1, DMA=1, store 5 accepted, STALL=0.
- Forwarding: buffer holds addr 7=0x11 then addr 7=0x22.
  - LD_ADDR=7 -> LD_DATA=0x22, LD_FWD=1.
  - LD_ADDR=8 with Mem[8]=0x99 -> LD_DATA=0x99, LD_FWD=0.
- Drain order: 4 entries queued (addr 1..4), 4 idle cycles -> DMWE=1 each cycle with DMA=1,2,3,4 in order; EMPTY=1 after the 4th edge; then DMWE=0.
- Reset mid-operation: 3 entries queued, RST_N=0 for one cycle -> EMPTY=1, DMWE=0 in following idle cycles; Mem at those addresses unchanged.
- Wrap-around: DEPTH=4, 10 stores interleaved with loads in an alternating pattern -> pointers wrap twice, final Mem contents match a reference model, no lost or duplicated writes.
